acc_drain: RTL

- Read-side master for the accumulator RAM.
- Sweeps a contiguous address range through the accumulator read port, which has a fixed 2-cycle latency.
- Returns each word on a valid/ready output stream, buffered so that backpressure never loses data.
- Optional clear-on-read: zeroes each drained location through the accumulator write port in overwrite mode, so the next accumulation batch starts from 0.

---
 rtl/acc_pkg.sv | 21 ++
 rtl/acc_drain_fifo.sv | 62 ++++++
 rtl/acc_drain.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator RAM drain path.
package acc_pkg;

  localparam int ACC_RD_LATENCY = 2;
  localparam int ACC_LANE_W     = 16;
  // Address width carried by a return tag; the drain's ADDR_WIDTH must equal it.
  localparam int ACC_ADDR_W     = 9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } drain_state_e;

  typedef struct packed {
    logic [ACC_ADDR_W-1:0] addr;
    logic                  last;
  } drain_tag_t;

endpackage

// File: rtl/acc_drain_fifo.sv
// Small synchronous FIFO with head-of-queue visibility, occupancy count and
// same-cycle push/pop (also legal when full).
module acc_drain_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = mem[rd_ptr_reg];

  // A pop frees the slot in the same cycle, so a full FIFO may still accept a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/acc_drain.sv
// Sweeps an address range of the accumulator RAM, streams every word out with
// backpressure, and optionally zeroes each location as it is captured.
module acc_drain
  import acc_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = ACC_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  clear_en,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  wr_en,
  output logic                  wr_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_wdata,
  output logic                  acc_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last
);

  localparam int LEN_W  = ADDR_WIDTH + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 2;
  localparam int FIFO_W = DATA_WIDTH + ADDR_WIDTH + 1;

  drain_state_e          state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_W-1:0]      len_reg;
  logic [LEN_W-1:0]      idx_reg;
  logic                  clear_reg;
  logic                  last_acc_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic [RD_LATENCY-1:0] pipe_valid_reg;
  logic [RD_LATENCY-1:0] pipe_valid_next;
  drain_tag_t [RD_LATENCY-1:0] pipe_tag_reg;
  drain_tag_t [RD_LATENCY-1:0] pipe_tag_next;
  drain_tag_t            issue_tag;
  drain_tag_t            exit_tag;

  logic [CNT_W-1:0]      in_flight;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_W-1:0]     fifo_head;
  logic                  capture;
  logic                  pop;
  logic                  head_last;

  assign issue_tag.addr = ACC_ADDR_W'(addr_reg);
  assign issue_tag.last = (idx_reg == len_reg - LEN_W'(1));

  // Return pipeline: stage 0 takes the tag of the read issued this cycle.
  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      assign pipe_valid_next[gi] = rd_en;
      assign pipe_tag_next[gi]   = issue_tag;
    end else begin : g_shift
      assign pipe_valid_next[gi] = pipe_valid_reg[gi-1];
      assign pipe_tag_next[gi]   = pipe_tag_reg[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_reg <= '0;
      pipe_tag_reg   <= '0;
    end else begin
      pipe_valid_reg <= pipe_valid_next;
      pipe_tag_reg   <= pipe_tag_next;
    end
  end

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + CNT_W'(pipe_valid_reg[i]);
    end
  end

  // Credit: every outstanding read already owns a FIFO slot, so data never overflows.
  assign rd_en   = (state_reg == RUN) &&
                   ((in_flight + CNT_W'(fifo_count)) < CNT_W'(FIFO_DEPTH));
  assign rd_addr = addr_reg;

  assign capture  = pipe_valid_reg[RD_LATENCY-1];
  assign exit_tag = pipe_tag_reg[RD_LATENCY-1];

  assign wr_en    = capture && clear_reg;
  assign wr_we    = wr_en;
  assign wr_addr  = wr_en ? ADDR_WIDTH'(exit_tag.addr) : '0;
  assign wr_wdata = '0;
  assign acc_mode = 1'b0;

  acc_drain_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data ({rd_rdata, ADDR_WIDTH'(exit_tag.addr), exit_tag.last}),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign head_last = fifo_head[0];
  assign out_last  = out_valid && head_last;
  assign out_addr  = out_valid ? fifo_head[ADDR_WIDTH:1] : '0;
  assign out_data  = out_valid ? fifo_head[FIFO_W-1 -: DATA_WIDTH] : '0;

  assign busy = busy_reg;
  assign done = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      len_reg      <= '0;
      idx_reg      <= '0;
      clear_reg    <= 1'b0;
      last_acc_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (pop && head_last) begin
        last_acc_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg     <= base_addr;
            len_reg      <= length;
            clear_reg    <= clear_en;
            idx_reg      <= '0;
            last_acc_reg <= 1'b0;
            if (length == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd_en) begin
            addr_reg <= addr_reg + 1'b1;
            idx_reg  <= idx_reg + 1'b1;
            if (issue_tag.last) begin
              state_reg <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (in_flight == '0 && fifo_empty && last_acc_reg) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule
